// File: rtl/tlb_miss_walker.sv
// Small fully-associative TLB in front of the page table: hits are answered locally,
// misses walk the table once and fill. Optional hit/miss statistics under `TLB_STATS_EN.
module tlb_miss_walker #(
    parameter int VPN_W        = 3,
    parameter int PTE_W        = 6,
    parameter int ENTRIES      = 4,
    parameter int WALK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             REQ_VALID,
    input  logic [VPN_W-1:0] REQ_VPN,
    output logic             REQ_READY,
    input  logic             FLUSH,
    output logic             RESP_VALID,
    output logic [PTE_W-1:0] RESP_PTE,
    output logic             RESP_HIT,
    output logic             RESP_FAULT,
    output logic             LOOKUP_RQST,
    output logic [VPN_W-1:0] LOOKUP_ADDR,
    input  logic             LOOKUP_COMPLETE,
    input  logic [PTE_W-1:0] LOOKUP_RETURN,
    output logic [15:0]      HIT_COUNT,
    output logic [15:0]      MISS_COUNT
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [3:0] TIMEOUT_CNT = 4'(WALK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_WALK,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ENTRIES-1:0] r_valid;
    logic [VPN_W-1:0]   r_tag [ENTRIES];
    logic [PTE_W-1:0]   r_pte [ENTRIES];
    logic [IDX_W-1:0]   r_rrPtr;

    logic [VPN_W-1:0]   r_vpn;
    logic [PTE_W-1:0]   r_respPte;
    logic               r_respHit;
    logic               r_respFault;
    logic [3:0]         r_waitCnt;
    logic               r_flushSeen;

    logic               w_hit;
    logic [IDX_W-1:0]   w_hitIdx;
    logic               w_haveFree;
    logic [IDX_W-1:0]   w_freeIdx;
    logic [IDX_W-1:0]   w_victim;
    logic               w_timeout;
    logic               w_fill;

    // Tag match; at most one entry can match since a VPN is only filled after a miss.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == r_vpn)) begin
                w_hit    = 1'b1;
                w_hitIdx = IDX_W'(i);
            end
        end
    end

    // Scan downwards so the lowest-index free entry wins.
    always_comb begin
        w_haveFree = 1'b0;
        w_freeIdx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_haveFree = 1'b1;
                w_freeIdx  = IDX_W'(i);
            end
        end
    end

    assign w_victim  = w_haveFree ? w_freeIdx : r_rrPtr;
    assign w_timeout = (r_waitCnt == TIMEOUT_CNT);
    // A flush anywhere during the walk, or on the completion edge itself, suppresses the fill.
    assign w_fill    = (r_state == S_WAIT) && LOOKUP_COMPLETE && LOOKUP_RETURN[PTE_W-1]
                       && !FLUSH && !r_flushSeen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        REQ_READY   = 1'b0;
        RESP_VALID  = 1'b0;
        LOOKUP_RQST = 1'b0;
        case (r_state)
            S_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    w_next = S_PROBE;
                end
            end
            S_PROBE: begin
                w_next = w_hit ? S_RESP : S_WALK;
            end
            S_WALK: begin
                LOOKUP_RQST = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (LOOKUP_COMPLETE || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                RESP_VALID = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpn       <= '0;
            r_respPte   <= '0;
            r_respHit   <= 1'b0;
            r_respFault <= 1'b0;
            r_waitCnt   <= 4'd0;
            r_flushSeen <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && REQ_VALID) begin
                r_vpn <= REQ_VPN;
            end

            if (r_state == S_PROBE) begin
                r_flushSeen <= 1'b0;
            end else if (FLUSH && ((r_state == S_WALK) || (r_state == S_WAIT))) begin
                r_flushSeen <= 1'b1;
            end

            case (r_state)
                S_PROBE: begin
                    if (w_hit) begin
                        r_respPte   <= r_pte[w_hitIdx];
                        r_respHit   <= 1'b1;
                        r_respFault <= 1'b0;
                    end
                end
                S_WALK: begin
                    r_waitCnt <= 4'd1;
                end
                S_WAIT: begin
                    // Completion on the final counted cycle still beats the timeout.
                    if (LOOKUP_COMPLETE) begin
                        r_respPte   <= LOOKUP_RETURN;
                        r_respHit   <= 1'b0;
                        r_respFault <= ~LOOKUP_RETURN[PTE_W-1];
                        r_waitCnt   <= 4'd0;
                    end else if (w_timeout) begin
                        r_respPte   <= '0;
                        r_respHit   <= 1'b0;
                        r_respFault <= 1'b1;
                        r_waitCnt   <= 4'd0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_rrPtr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_pte[i] <= '0;
            end
        end else if (FLUSH) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_victim] <= 1'b1;
            r_tag[w_victim]   <= r_vpn;
            r_pte[w_victim]   <= LOOKUP_RETURN;
            if (!w_haveFree) begin
                r_rrPtr <= r_rrPtr + 1'b1;
            end
        end
    end

    assign RESP_PTE    = r_respPte;
    assign RESP_HIT    = r_respHit;
    assign RESP_FAULT  = r_respFault;
    assign LOOKUP_ADDR = r_vpn;

`ifdef TLB_STATS_EN
    logic [15:0] r_hitCount;
    logic [15:0] r_missCount;

    // Saturating counters; only reset clears them, a flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hitCount  <= 16'd0;
            r_missCount <= 16'd0;
        end else if (r_state == S_PROBE) begin
            if (w_hit) begin
                if (r_hitCount != 16'hFFFF) begin
                    r_hitCount <= r_hitCount + 16'd1;
                end
            end else begin
                if (r_missCount != 16'hFFFF) begin
                    r_missCount <= r_missCount + 16'd1;
                end
            end
        end
    end

    assign HIT_COUNT  = r_hitCount;
    assign MISS_COUNT = r_missCount;
`else
    assign HIT_COUNT  = 16'd0;
    assign MISS_COUNT = 16'd0;
`endif

endmodule
